// File: rtl/carfield_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : carfield_mailbox
//  Description : Two-sided message mailbox between the Cheshire host and the
//                security island. There are two message FIFOs: H2I (host
//                pushes, island pops) and I2H (island pushes, host pops).
//                Each side also has a status register and a level interrupt.
//                That interrupt fires when a message arrives in the side's
//                receive FIFO.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports (the host_* set and the isl_* set are identical)
//    clk_i            single clock for all logic
//    rst_i            synchronous, active-high reset
//    *_req_i          access request
//    *_we_i           1 = write, 0 = read
//    *_addr_i [11:0]  byte offset within the 4 KiB mailbox window
//    *_wdata_i        write data
//    *_gnt_o          request accepted (1 whenever not in reset)
//    *_rvalid_o       response valid, exactly one cycle after each request
//    *_rdata_o        read data (0 on writes and on errors)
//    *_err_o          response error, qualified by *_rvalid_o
//    *_irq_o          registered level interrupt: IRQ_EN[0] & IRQ_PEND[0]
//  Register map (per side)
//    0x00 TX_DATA  W    push into own TX FIFO
//    0x04 RX_DATA  R    pop from own RX FIFO
//    0x08 STATUS   R    {rx_count[15:8], tx_full, tx_empty, rx_full, rx_empty}
//    0x0C IRQ_EN   R/W  bit0
//    0x10 IRQ_PEND R/W1C bit0
// ============================================================================
module carfield_mailbox #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 host_req_i,
    input  logic                 host_we_i,
    input  logic [11:0]          host_addr_i,
    input  logic [DataWidth-1:0] host_wdata_i,
    output logic                 host_gnt_o,
    output logic                 host_rvalid_o,
    output logic [DataWidth-1:0] host_rdata_o,
    output logic                 host_err_o,
    output logic                 host_irq_o,
    input  logic                 isl_req_i,
    input  logic                 isl_we_i,
    input  logic [11:0]          isl_addr_i,
    input  logic [DataWidth-1:0] isl_wdata_i,
    output logic                 isl_gnt_o,
    output logic                 isl_rvalid_o,
    output logic [DataWidth-1:0] isl_rdata_o,
    output logic                 isl_err_o,
    output logic                 isl_irq_o
);

    localparam int unsigned        c_PTR_W   = $clog2(Depth);
    localparam int unsigned        c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(Depth);
    localparam logic [11:0]        c_OFF_TX   = 12'h000;
    localparam logic [11:0]        c_OFF_RX   = 12'h004;
    localparam logic [11:0]        c_OFF_STAT = 12'h008;
    localparam logic [11:0]        c_OFF_EN   = 12'h00C;
    localparam logic [11:0]        c_OFF_PEND = 12'h010;

    // Index 0 is the host side and index 1 is the island side. FIFO f is
    // pushed by side f and popped by side 1-f, so side s transmits into
    // FIFO s and receives from FIFO 1-s.
    logic [1:0]           w_req;
    logic [1:0]           w_we;
    logic [11:0]          w_addr   [2];
    logic [DataWidth-1:0] w_wdata  [2];
    logic [1:0]           w_push;
    logic [1:0]           w_pop;
    logic [1:0]           w_full;
    logic [1:0]           w_empty;
    logic [c_CNT_W-1:0]   w_count  [2];
    logic [DataWidth-1:0] w_head   [2];
    logic [1:0]           w_rvalid;
    logic [1:0]           w_err;
    logic [1:0]           w_irq;
    logic [DataWidth-1:0] w_rdata  [2];

    assign w_req      = {isl_req_i, host_req_i};
    assign w_we       = {isl_we_i, host_we_i};
    assign w_addr[0]  = host_addr_i;
    assign w_addr[1]  = isl_addr_i;
    assign w_wdata[0] = host_wdata_i;
    assign w_wdata[1] = isl_wdata_i;

    assign host_gnt_o    = ~rst_i;
    assign isl_gnt_o     = ~rst_i;
    assign host_rvalid_o = w_rvalid[0];
    assign isl_rvalid_o  = w_rvalid[1];
    assign host_rdata_o  = w_rdata[0];
    assign isl_rdata_o   = w_rdata[1];
    assign host_err_o    = w_err[0];
    assign isl_err_o     = w_err[1];
    assign host_irq_o    = w_irq[0];
    assign isl_irq_o     = w_irq[1];

    // ------------------------------------------------------------------
    // Message FIFOs
    // ------------------------------------------------------------------
    for (genvar f = 0; f < 2; f++) begin : g_fifo
        logic [DataWidth-1:0] r_mem [Depth];
        logic [c_PTR_W-1:0]   r_wptr;
        logic [c_PTR_W-1:0]   r_rptr;
        logic [c_CNT_W-1:0]   r_count;
        logic                 w_doPush;
        logic                 w_doPop;

        assign w_doPush = w_push[f];
        assign w_doPop  = w_pop[1-f];

        // Depth is a power of two, so pointers wrap naturally at Depth-1.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_doPush) r_wptr <= r_wptr + c_PTR_W'(1);
                if (w_doPop)  r_rptr <= r_rptr + c_PTR_W'(1);
                case ({w_doPush, w_doPop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        // Storage is not reset; the reset pointers make old contents invisible.
        always_ff @(posedge clk_i) begin
            if (w_doPush) r_mem[r_wptr] <= w_wdata[f];
        end

        assign w_full[f]  = (r_count == c_DEPTH);
        assign w_empty[f] = (r_count == '0);
        assign w_count[f] = r_count;
        assign w_head[f]  = r_mem[r_rptr];
    end

    // ------------------------------------------------------------------
    // Per-side register interface
    // ------------------------------------------------------------------
    for (genvar s = 0; s < 2; s++) begin : g_side
        logic                 r_rvalid;
        logic                 r_err;
        logic [DataWidth-1:0] r_rdata;
        logic                 r_irqEn;
        logic                 r_irqPend;
        logic                 r_irq;
        logic                 w_isTx;
        logic                 w_isRx;
        logic                 w_isStat;
        logic                 w_isEn;
        logic                 w_isPend;
        logic                 w_doPush;
        logic                 w_doPop;
        logic                 w_enWr;
        logic                 w_pendClr;
        logic                 w_pendSet;
        logic                 w_respErr;
        logic [DataWidth-1:0] w_respData;

        // Exact offset matches also reject unaligned addresses.
        assign w_isTx   = (w_addr[s] == c_OFF_TX);
        assign w_isRx   = (w_addr[s] == c_OFF_RX);
        assign w_isStat = (w_addr[s] == c_OFF_STAT);
        assign w_isEn   = (w_addr[s] == c_OFF_EN);
        assign w_isPend = (w_addr[s] == c_OFF_PEND);

        // A message landing in this side's RX FIFO raises the pending flag.
        assign w_pendSet = w_push[1-s];

        always_comb begin
            w_doPush   = 1'b0;
            w_doPop    = 1'b0;
            w_enWr     = 1'b0;
            w_pendClr  = 1'b0;
            w_respErr  = w_req[s];
            w_respData = '0;
            if (w_req[s]) begin
                if (w_we[s]) begin
                    if (w_isTx) begin
                        // Full is judged before any same-cycle pop.
                        w_respErr = w_full[s];
                        w_doPush  = ~w_full[s];
                    end else if (w_isEn) begin
                        w_respErr = 1'b0;
                        w_enWr    = 1'b1;
                    end else if (w_isPend) begin
                        w_respErr = 1'b0;
                        w_pendClr = w_wdata[s][0];
                    end
                end else begin
                    if (w_isRx) begin
                        w_respErr = w_empty[1-s];
                        w_doPop   = ~w_empty[1-s];
                        if (!w_empty[1-s]) w_respData = w_head[1-s];
                    end else if (w_isStat) begin
                        w_respErr        = 1'b0;
                        w_respData[15:8] = {{(8-c_CNT_W){1'b0}}, w_count[1-s]};
                        w_respData[3:0]  = {w_full[s], w_empty[s], w_full[1-s], w_empty[1-s]};
                    end else if (w_isEn) begin
                        w_respErr     = 1'b0;
                        w_respData[0] = r_irqEn;
                    end else if (w_isPend) begin
                        w_respErr     = 1'b0;
                        w_respData[0] = r_irqPend;
                    end
                end
            end
        end

        assign w_push[s] = w_doPush;
        assign w_pop[s]  = w_doPop;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_rvalid  <= 1'b0;
                r_err     <= 1'b0;
                r_rdata   <= '0;
                r_irqEn   <= 1'b0;
                r_irqPend <= 1'b0;
                r_irq     <= 1'b0;
            end else begin
                r_rvalid <= w_req[s];
                r_err    <= w_respErr;
                r_rdata  <= w_respData;
                if (w_enWr) r_irqEn <= w_wdata[s][0];
                // A set in the same cycle as a W1C wins.
                r_irqPend <= w_pendSet | (r_irqPend & ~w_pendClr);
                r_irq     <= r_irqEn & r_irqPend;
            end
        end

        assign w_rvalid[s] = r_rvalid;
        assign w_err[s]    = r_err;
        assign w_rdata[s]  = r_rdata;
        assign w_irq[s]    = r_irq;
    end

endmodule
`default_nettype wire

// File: tb/tb_carfield_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carfield_mailbox
//  Description : Scoreboard bench for carfield_mailbox. Stimulus tasks queue
//                the expected response of every request; a monitor pops and
//                compares whenever a side presents rvalid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_carfield_mailbox;

    localparam int unsigned Depth     = 4;
    localparam int unsigned DataWidth = 32;

    logic        clk_i        = 1'b0;
    logic        rst_i        = 1'b1;
    logic        host_req_i   = 1'b0;
    logic        host_we_i    = 1'b0;
    logic [11:0] host_addr_i  = '0;
    logic [31:0] host_wdata_i = '0;
    logic        host_gnt_o;
    logic        host_rvalid_o;
    logic [31:0] host_rdata_o;
    logic        host_err_o;
    logic        host_irq_o;
    logic        isl_req_i    = 1'b0;
    logic        isl_we_i     = 1'b0;
    logic [11:0] isl_addr_i   = '0;
    logic [31:0] isl_wdata_i  = '0;
    logic        isl_gnt_o;
    logic        isl_rvalid_o;
    logic [31:0] isl_rdata_o;
    logic        isl_err_o;
    logic        isl_irq_o;

    carfield_mailbox #(.Depth(Depth), .DataWidth(DataWidth)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .host_req_i    (host_req_i),
        .host_we_i     (host_we_i),
        .host_addr_i   (host_addr_i),
        .host_wdata_i  (host_wdata_i),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .host_irq_o    (host_irq_o),
        .isl_req_i     (isl_req_i),
        .isl_we_i      (isl_we_i),
        .isl_addr_i    (isl_addr_i),
        .isl_wdata_i   (isl_wdata_i),
        .isl_gnt_o     (isl_gnt_o),
        .isl_rvalid_o  (isl_rvalid_o),
        .isl_rdata_o   (isl_rdata_o),
        .isl_err_o     (isl_err_o),
        .isl_irq_o     (isl_irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t qH[$];
    exp_t qI[$];
    exp_t eH;
    exp_t eI;
    int   nChecks = 0;
    int   nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk_i) begin
        if (host_rvalid_o) begin
            if (qH.size() == 0) begin
                check("host_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                eH = qH.pop_front();
                check("host_rdata", host_rdata_o, eH.data);
                check("host_err", {31'b0, host_err_o}, {31'b0, eH.err});
            end
        end
        if (isl_rvalid_o) begin
            if (qI.size() == 0) begin
                check("isl_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                eI = qI.pop_front();
                check("isl_rdata", isl_rdata_o, eI.data);
                check("isl_err", {31'b0, isl_err_o}, {31'b0, eI.err});
            end
        end
    end

    task automatic hostAcc(input logic we, input logic [11:0] a, input logic [31:0] wd,
                           input logic [31:0] ed, input logic ee);
        host_req_i   = 1'b1;
        host_we_i    = we;
        host_addr_i  = a;
        host_wdata_i = wd;
        qH.push_back('{data: ed, err: ee});
    endtask

    task automatic islAcc(input logic we, input logic [11:0] a, input logic [31:0] wd,
                          input logic [31:0] ed, input logic ee);
        isl_req_i   = 1'b1;
        isl_we_i    = we;
        isl_addr_i  = a;
        isl_wdata_i = wd;
        qI.push_back('{data: ed, err: ee});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        host_req_i = 1'b0;
        isl_req_i  = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_host_gnt", {31'b0, host_gnt_o}, 32'd0);
        check("rst_isl_gnt", {31'b0, isl_gnt_o}, 32'd0);
        check("rst_rvalid", {30'b0, host_rvalid_o, isl_rvalid_o}, 32'd0);
        check("rst_irq", {30'b0, host_irq_o, isl_irq_o}, 32'd0);
        check("rst_rdata", host_rdata_o | isl_rdata_o, 32'd0);
        rst_i = 1'b0;
        #1;
        check("gnt_after_rst", {30'b0, host_gnt_o, isl_gnt_o}, 32'd3);

        // Single message host -> island
        hostAcc(1'b1, 12'h000, 32'hA5A5_0001, 32'h0, 1'b0);
        step();
        islAcc(1'b0, 12'h004, 32'h0, 32'hA5A5_0001, 1'b0);
        step();
        // rx_empty and tx_empty both set
        islAcc(1'b0, 12'h008, 32'h0, 32'h0000_0005, 1'b0);
        step();

        // Overfill: fifth push is dropped
        for (int i = 0; i < 5; i++) begin
            hostAcc(1'b1, 12'h000, 32'h100 + i, 32'h0, (i == 4));
            step();
        end
        hostAcc(1'b0, 12'h008, 32'h0, 32'h0000_0009, 1'b0);
        islAcc(1'b0, 12'h008, 32'h0, 32'h0000_0406, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            islAcc(1'b0, 12'h004, 32'h0, (i == 4) ? 32'h0 : 32'h100 + i, (i == 4));
            step();
        end

        // Island interrupt
        islAcc(1'b1, 12'h010, 32'h1, 32'h0, 1'b0);
        step();
        islAcc(1'b0, 12'h010, 32'h0, 32'h0, 1'b0);
        step();
        islAcc(1'b1, 12'h00C, 32'h1, 32'h0, 1'b0);
        step();
        step();
        check("isl_irq_idle", {31'b0, isl_irq_o}, 32'd0);
        hostAcc(1'b1, 12'h000, 32'h1234, 32'h0, 1'b0);
        step();
        check("isl_irq_1cyc", {31'b0, isl_irq_o}, 32'd0);
        step();
        check("isl_irq_2cyc", {31'b0, isl_irq_o}, 32'd1);
        islAcc(1'b0, 12'h010, 32'h0, 32'h1, 1'b0);
        step();
        islAcc(1'b1, 12'h010, 32'h1, 32'h0, 1'b0);
        step();
        check("isl_irq_clr_1cyc", {31'b0, isl_irq_o}, 32'd1);
        islAcc(1'b0, 12'h004, 32'h0, 32'h1234, 1'b0);
        step();
        check("isl_irq_clr_2cyc", {31'b0, isl_irq_o}, 32'd0);
        check("host_irq_disabled", {31'b0, host_irq_o}, 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            hostAcc(1'b1, 12'h000, 32'h200 + i, 32'h0, 1'b0);
            step();
        end
        hostAcc(1'b1, 12'h000, 32'h77, 32'h0, 1'b1);
        islAcc(1'b0, 12'h004, 32'h0, 32'h200, 1'b0);
        step();
        islAcc(1'b0, 12'h008, 32'h0, 32'h0000_0304, 1'b0);
        step();
        islAcc(1'b0, 12'h004, 32'h0, 32'h201, 1'b0);
        step();
        hostAcc(1'b1, 12'h000, 32'h78, 32'h0, 1'b0);
        islAcc(1'b0, 12'h004, 32'h0, 32'h202, 1'b0);
        step();
        islAcc(1'b0, 12'h008, 32'h0, 32'h0000_0204, 1'b0);
        step();
        islAcc(1'b0, 12'h004, 32'h0, 32'h203, 1'b0);
        step();
        islAcc(1'b0, 12'h004, 32'h0, 32'h78, 1'b0);
        step();

        // Alternating traffic across the wrap point
        for (int i = 0; i < 6; i++) begin
            hostAcc(1'b1, 12'h000, 32'h300 + i, 32'h0, 1'b0);
            step();
            islAcc(1'b0, 12'h004, 32'h0, 32'h300 + i, 1'b0);
            step();
        end
        islAcc(1'b0, 12'h008, 32'h0, 32'h0000_0005, 1'b0);
        step();

        // Island -> host direction
        islAcc(1'b1, 12'h000, 32'hBEEF, 32'h0, 1'b0);
        step();
        hostAcc(1'b0, 12'h008, 32'h0, 32'h0000_0104, 1'b0);
        step();
        hostAcc(1'b0, 12'h004, 32'h0, 32'hBEEF, 1'b0);
        step();

        // Illegal accesses
        hostAcc(1'b0, 12'h002, 32'h0, 32'h0, 1'b1);
        islAcc(1'b1, 12'h020, 32'h5, 32'h0, 1'b1);
        step();
        hostAcc(1'b1, 12'h008, 32'h5, 32'h0, 1'b1);
        islAcc(1'b0, 12'h000, 32'h0, 32'h0, 1'b1);
        step();
        hostAcc(1'b1, 12'h004, 32'h5, 32'h0, 1'b1);
        islAcc(1'b0, 12'h014, 32'h0, 32'h0, 1'b1);
        step();

        // Reset with queued messages and a request in flight
        for (int i = 0; i < 3; i++) begin
            hostAcc(1'b1, 12'h000, 32'h400 + i, 32'h0, 1'b0);
            step();
        end
        islAcc(1'b0, 12'h008, 32'h0, 32'h0000_0304, 1'b0);
        step();
        rst_i       = 1'b1;
        host_req_i  = 1'b1;
        host_we_i   = 1'b0;
        host_addr_i = 12'h008;
        step();
        check("midrst_rvalid", {30'b0, host_rvalid_o, isl_rvalid_o}, 32'd0);
        check("midrst_gnt", {30'b0, host_gnt_o, isl_gnt_o}, 32'd0);
        step();
        rst_i = 1'b0;
        check("postrst_irq", {30'b0, host_irq_o, isl_irq_o}, 32'd0);
        islAcc(1'b0, 12'h008, 32'h0, 32'h0000_0005, 1'b0);
        hostAcc(1'b0, 12'h008, 32'h0, 32'h0000_0005, 1'b0);
        step();
        islAcc(1'b0, 12'h004, 32'h0, 32'h0, 1'b1);
        hostAcc(1'b0, 12'h00C, 32'h0, 32'h0, 1'b0);
        step();
        islAcc(1'b0, 12'h00C, 32'h0, 32'h0, 1'b0);
        step();
        step();
        step();
        check("host_missing_responses", qH.size(), 32'd0);
        check("isl_missing_responses", qI.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
